// File: rtl/memoredf_pkg.sv
// Shared definitions for the memoredf output path: packet header layout,
// beat geometry and the serializer state encoding.
package memoredf_pkg;

    // Packet geometry: 102-bit header, then 4 strobe beats, then 4 data beats
    localparam int PKT_W       = 678;
    localparam int HDR_W       = 102;
    localparam int NUM_BEATS   = 4;
    localparam int BEAT_IDX_W  = 2;
    localparam int BEAT_DATA_W = 128;
    localparam int BEAT_STRB_W = 16;
    localparam int STRB_LSB    = 102;
    localparam int DATA_LSB    = 166;
    localparam int STRB_BITS   = NUM_BEATS * BEAT_STRB_W;
    localparam int DATA_BITS   = NUM_BEATS * BEAT_DATA_W;

    // Header field offsets and widths
    localparam int HDR_ADDR_LSB  = 0;
    localparam int HDR_ADDR_W    = 40;
    localparam int HDR_ID_LSB    = 40;
    localparam int HDR_ID_W      = 16;
    localparam int HDR_LEN_LSB   = 56;
    localparam int HDR_LEN_W     = 8;
    localparam int HDR_SIZE_LSB  = 64;
    localparam int HDR_SIZE_W    = 3;
    localparam int HDR_BURST_LSB = 67;
    localparam int HDR_BURST_W   = 2;
    localparam int HDR_WRITE_BIT = 69;
    localparam int HDR_RSVD_W    = 32;

    // Header as a packed struct; first member is the MSB end
    typedef struct packed {
        logic [HDR_RSVD_W-1:0]  reserved;
        logic                   is_write;
        logic [HDR_BURST_W-1:0] burst;
        logic [HDR_SIZE_W-1:0]  size;
        logic [HDR_LEN_W-1:0]   len;
        logic [HDR_ID_W-1:0]    id;
        logic [HDR_ADDR_W-1:0]  addr;
    } packet_hdr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } ser_state_t;

    // Write bursts never exceed the four beats carried by a packet
    function automatic logic [BEAT_IDX_W-1:0] eff_len(input logic [HDR_LEN_W-1:0] len);
        return (len > 8'd3) ? 2'd3 : len[BEAT_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/packet_serializer_beat_extractor.sv
// Combinational beat selector: picks the data and strobe slice for one
// W beat out of the captured packet payload.
module beat_extractor
    import memoredf_pkg::*;
(
    input  logic [DATA_BITS-1:0]   data_beats,
    input  logic [STRB_BITS-1:0]   strb_beats,
    input  logic [BEAT_IDX_W-1:0]  beat,
    output logic [BEAT_DATA_W-1:0] beat_data,
    output logic [BEAT_STRB_W-1:0] beat_strb
);

    assign beat_data = data_beats[beat * BEAT_DATA_W +: BEAT_DATA_W];
    assign beat_strb = strb_beats[beat * BEAT_STRB_W +: BEAT_STRB_W];

endmodule

// File: rtl/packet_serializer.sv
// packet_serializer: captures a scheduled packet, acknowledges it with a
// one-cycle consumed pulse and replays it as an AXI4 read (AR) or write
// (AW + up to four W beats). All AXI fields come from the captured copy.
// Build option: SERIALIZER_PERF_COUNTERS_EN enables pkt_count/stall_count.
module packet_serializer
    import memoredf_pkg::*;
#(
    parameter int DATA_SIZE  = 678,
    parameter int ID_WIDTH   = 16,
    parameter int ADDR_WIDTH = 40,
    parameter int HOLDOFF    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_SIZE-1:0]  packet,
    input  logic                  activate,
    output logic                  consumed,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [127:0]          m_axi_wdata,
    output logic [15:0]           m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic                  len_error,
    output logic [31:0]           pkt_count,
    output logic [31:0]           stall_count
);

    localparam int HO_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    ser_state_t              state;
    packet_hdr_t             hdr_in;
    logic [HO_W-1:0]         holdoff;
    logic [BEAT_IDX_W-1:0]   beat;
    logic [BEAT_IDX_W-1:0]   eff_len_q;
    logic [HDR_ADDR_W-1:0]   addr_q;
    logic [HDR_ID_W-1:0]     id_q;
    logic [HDR_LEN_W-1:0]    len_q;
    logic [HDR_SIZE_W-1:0]   size_q;
    logic [HDR_BURST_W-1:0]  burst_q;
    logic                    is_write_q;
    logic [STRB_BITS-1:0]    strb_q;
    logic [DATA_BITS-1:0]    data_q;
    logic                    capture;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;

    assign hdr_in  = packet_hdr_t'(packet[HDR_W-1:0]);
    assign capture = (state == IDLE) && activate && (holdoff == '0);
    assign aw_hs   = m_axi_awvalid && m_axi_awready;
    assign w_hs    = m_axi_wvalid && m_axi_wready;
    assign ar_hs   = m_axi_arvalid && m_axi_arready;

    // Valids derive from the state flops so a reset drops them immediately
    assign m_axi_awvalid = (state == ADDR) && is_write_q;
    assign m_axi_arvalid = (state == ADDR) && !is_write_q;
    assign m_axi_wvalid  = (state == DATA);
    assign m_axi_wlast   = (state == DATA) && (beat == eff_len_q);

    assign m_axi_awid    = ID_WIDTH'(id_q);
    assign m_axi_awaddr  = ADDR_WIDTH'(addr_q);
    assign m_axi_awlen   = {6'd0, eff_len_q};
    assign m_axi_awsize  = size_q;
    assign m_axi_awburst = burst_q;
    assign m_axi_arid    = ID_WIDTH'(id_q);
    assign m_axi_araddr  = ADDR_WIDTH'(addr_q);
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = size_q;
    assign m_axi_arburst = burst_q;

    beat_extractor u_beat_extractor (
        .data_beats (data_q),
        .strb_beats (strb_q),
        .beat       (beat),
        .beat_data  (m_axi_wdata),
        .beat_strb  (m_axi_wstrb)
    );

    // Serializer FSM: capture in IDLE, address phase, then write beats
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (capture) state <= ADDR;
                ADDR: begin
                    if (is_write_q && aw_hs)       state <= DATA;
                    else if (!is_write_q && ar_hs) state <= IDLE;
                end
                DATA: if (w_hs && m_axi_wlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // W beat index: advances per handshake, rewinds after the last beat
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat <= '0;
        end else if (w_hs) begin
            beat <= m_axi_wlast ? '0 : beat + 2'd1;
        end
    end

    // Captured packet copy; the live input may move on after consumed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            is_write_q <= 1'b0;
            eff_len_q  <= '0;
            strb_q     <= '0;
            data_q     <= '0;
        end else if (capture) begin
            addr_q     <= hdr_in.addr;
            id_q       <= hdr_in.id;
            len_q      <= hdr_in.len;
            size_q     <= hdr_in.size;
            burst_q    <= hdr_in.burst;
            is_write_q <= hdr_in.is_write;
            eff_len_q  <= eff_len(hdr_in.len);
            strb_q     <= packet[STRB_LSB +: STRB_BITS];
            data_q     <= packet[DATA_LSB +: DATA_BITS];
        end
    end

    // Handshake back to the scheduler plus sticky overlong-write flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            consumed  <= 1'b0;
            len_error <= 1'b0;
        end else begin
            consumed <= capture;
            if (capture && hdr_in.is_write && (hdr_in.len > 8'd3)) len_error <= 1'b1;
        end
    end

    // Holdoff gives the scheduler and selector time to advance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            holdoff <= '0;
        end else if (consumed) begin
            holdoff <= HO_W'(HOLDOFF);
        end else if (holdoff != '0) begin
            holdoff <= holdoff - 1'b1;
        end
    end

`ifdef SERIALIZER_PERF_COUNTERS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        stall;

    assign stall = (m_axi_awvalid && !m_axi_awready) ||
                   (m_axi_wvalid  && !m_axi_wready)  ||
                   (m_axi_arvalid && !m_axi_arready);

    // Free-running wrap-around performance counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (ar_hs || (w_hs && m_axi_wlast)) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign pkt_count   = pkt_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign pkt_count   = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_packet_serializer.sv
// Scoreboard bench for packet_serializer: stimulus pushes expected AXI
// transactions into queues, negedge monitors pop and compare on handshakes.
module tb_packet_serializer;

    logic         clock = 1'b0;
    logic         reset;
    logic [677:0] packet;
    logic         activate;
    logic         consumed;
    logic [15:0]  m_axi_awid;
    logic [39:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_awvalid;
    logic         m_axi_awready;
    logic [127:0] m_axi_wdata;
    logic [15:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready;
    logic [15:0]  m_axi_arid;
    logic [39:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic         len_error;
    logic [31:0]  pkt_count;
    logic [31:0]  stall_count;

    always #5 clock = ~clock;

    packet_serializer dut (
        .clock(clock), .reset(reset), .packet(packet), .activate(activate),
        .consumed(consumed),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .len_error(len_error), .pkt_count(pkt_count), .stall_count(stall_count)
    );

    typedef struct packed {
        logic [15:0] id;
        logic [39:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } addr_txn_t;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
    } w_txn_t;

    addr_txn_t exp_aw[$];
    addr_txn_t exp_ar[$];
    w_txn_t    exp_w[$];
    addr_txn_t mon_a;
    w_txn_t    mon_w;
    int        cons_cyc[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int cons_cnt = 0;
    logic         w_prev_stall = 1'b0;
    logic [127:0] w_prev_data = '0;
    logic         w_toggle = 1'b0;
    logic         w_level = 1'b1;
    logic         snap_arvalid, snap_awvalid, snap_len_error;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: handshake with empty expectation queue at cycle %0d", name, cyc);
    endtask

    function automatic logic [677:0] mk_pkt(input logic wr, input logic [39:0] addr,
                                            input logic [15:0] id, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input logic [63:0] strb, input logic [511:0] data);
        return {data, strb, 32'hDEAD_BEEF, wr, burst, size, len, id, addr};
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // wready source: either a fixed level or a per-cycle toggle
    always @(posedge clock) begin
        #1;
        if (w_toggle) m_axi_wready = ~m_axi_wready;
        else          m_axi_wready = w_level;
    end

    // Monitors: compare each handshake against the scoreboard queues
    always @(negedge clock) begin
        if (m_axi_arvalid && m_axi_arready) begin
            if (exp_ar.size() == 0) unexpected("ar_unexpected");
            else begin
                mon_a = exp_ar.pop_front();
                check("ar_id", m_axi_arid, mon_a.id);
                check("ar_addr", m_axi_araddr, mon_a.addr);
                check("ar_len", m_axi_arlen, mon_a.len);
                check("ar_size_burst", {m_axi_arsize, m_axi_arburst}, {mon_a.size, mon_a.burst});
            end
        end
        if (m_axi_awvalid && m_axi_awready) begin
            if (exp_aw.size() == 0) unexpected("aw_unexpected");
            else begin
                mon_a = exp_aw.pop_front();
                check("aw_id", m_axi_awid, mon_a.id);
                check("aw_addr", m_axi_awaddr, mon_a.addr);
                check("aw_len", m_axi_awlen, mon_a.len);
                check("aw_size_burst", {m_axi_awsize, m_axi_awburst}, {mon_a.size, mon_a.burst});
            end
        end
        if (m_axi_wvalid) begin
            if (w_prev_stall) check("w_stable", m_axi_wdata, w_prev_data);
            if (m_axi_wready) begin
                if (exp_w.size() == 0) unexpected("w_unexpected");
                else begin
                    mon_w = exp_w.pop_front();
                    check("w_data", m_axi_wdata, mon_w.data);
                    check("w_strb", m_axi_wstrb, mon_w.strb);
                    check("w_last", m_axi_wlast, mon_w.last);
                end
            end
        end
        w_prev_stall = m_axi_wvalid && !m_axi_wready && reset;
        w_prev_data  = m_axi_wdata;
        if (consumed) begin
            cons_cnt++;
            cons_cyc.push_back(cyc);
        end
    end

    // Present a packet until consumed is seen; lat counts negedges waited
    task automatic issue(input logic [677:0] p, output int lat);
        bit got = 0;
        lat = 0;
        @(posedge clock); #1;
        packet = p;
        activate = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (consumed) begin
                got = 1;
                lat = i + 1;
                break;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL consumed_timeout: got no consumed pulse, required one within 40 cycles");
        end
        snap_arvalid   = m_axi_arvalid;
        snap_awvalid   = m_axi_awvalid;
        snap_len_error = len_error;
        @(posedge clock); #1;
        activate = 1'b0;
        packet = ~p;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80; i++) begin
            if (exp_ar.size() == 0 && exp_aw.size() == 0 && exp_w.size() == 0) break;
            @(negedge clock);
        end
        check(name, exp_ar.size() + exp_aw.size() + exp_w.size(), 0);
    endtask

    logic [127:0] dv [4];
    logic [127:0] ev [4];
    logic [15:0]  sv [4];

    initial begin
        int lat;
        int base;
        bit got;

        dv[0] = 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
        dv[1] = 128'h1011_1213_1415_1617_1819_1A1B_1C1D_1E1F;
        dv[2] = 128'h2021_2223_2425_2627_2829_2A2B_2C2D_2E2F;
        dv[3] = 128'h3031_3233_3435_3637_3839_3A3B_3C3D_3E3F;
        ev[0] = 128'hAAAA_0000_0000_0000_0000_0000_0000_0001;
        ev[1] = 128'hBBBB_0000_0000_0000_0000_0000_0000_0002;
        ev[2] = 128'hCCCC_0000_0000_0000_0000_0000_0000_0003;
        ev[3] = 128'hDDDD_0000_0000_0000_0000_0000_0000_0004;
        sv[0] = 16'h000F; sv[1] = 16'h00F0; sv[2] = 16'h0F00; sv[3] = 16'hF000;

        reset = 1'b0;
        packet = '0;
        activate = 1'b0;
        m_axi_awready = 1'b1;
        m_axi_arready = 1'b1;
        m_axi_wready = 1'b1;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_consumed", consumed, 0);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_wlast}, 0);
        check("rst_len_error", len_error, 0);
        check("rst_counters", {pkt_count, stall_count}, 0);
        check("rst_payload", {m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_wstrb}, 0);
        check("rst_wdata", m_axi_wdata, 0);
        reset = 1'b1;

        // Test 1: single read
        exp_ar.push_back('{id: 16'd3, addr: 40'h10_00, len: 8'd0, size: 3'd4, burst: 2'd1});
        issue(mk_pkt(1'b0, 40'h1000, 16'd3, 8'd0, 3'd4, 2'd1, 64'h0, 512'h0), lat);
        check("rd_consumed_latency", lat, 2);
        check("rd_arvalid_with_consumed", snap_arvalid, 1);
        check("rd_no_awvalid", snap_awvalid, 0);
        drain("rd_drain");

        // Test 2: four-beat write with wready toggling
        exp_aw.push_back('{id: 16'h0007, addr: 40'h20_00, len: 8'd3, size: 3'd4, burst: 2'd1});
        for (int k = 0; k < 4; k++)
            exp_w.push_back('{data: dv[k], strb: 16'hFFFF, last: (k == 3)});
        w_toggle = 1'b1;
        issue(mk_pkt(1'b1, 40'h2000, 16'h0007, 8'd3, 3'd4, 2'd1, {4{16'hFFFF}},
                     {dv[3], dv[2], dv[1], dv[0]}), lat);
        drain("wr4_drain");
        w_toggle = 1'b0;
        @(negedge clock);
        check("wr4_no_len_error", len_error, 0);

        // Test 3: activate held across two packets
        exp_ar.push_back('{id: 16'h0055, addr: 40'h40_00, len: 8'd1, size: 3'd2, burst: 2'd0});
        exp_ar.push_back('{id: 16'h0055, addr: 40'h40_00, len: 8'd1, size: 3'd2, burst: 2'd0});
        base = cons_cnt;
        got = 0;
        @(posedge clock); #1;
        packet = mk_pkt(1'b0, 40'h4000, 16'h0055, 8'd1, 3'd2, 2'd0, 64'h0, 512'h0);
        activate = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (cons_cnt - base >= 2) begin
                got = 1;
                break;
            end
        end
        @(posedge clock); #1;
        activate = 1'b0;
        repeat (10) @(negedge clock);
        check("held_pulses", cons_cnt - base, 2);
        if (got)
            check("held_spacing_at_least_4",
                  (cons_cyc[cons_cyc.size()-1] - cons_cyc[cons_cyc.size()-2]) >= 4, 1);
        drain("held_drain");

        // Test 4: overlong write, then a read with len passed through
        exp_aw.push_back('{id: 16'd9, addr: 40'h30_00, len: 8'd3, size: 3'd4, burst: 2'd1});
        for (int k = 0; k < 4; k++)
            exp_w.push_back('{data: ev[k], strb: sv[k], last: (k == 3)});
        issue(mk_pkt(1'b1, 40'h3000, 16'd9, 8'd7, 3'd4, 2'd1, {sv[3], sv[2], sv[1], sv[0]},
                     {ev[3], ev[2], ev[1], ev[0]}), lat);
        check("long_len_error_at_consumed", snap_len_error, 1);
        drain("long_drain");
        exp_ar.push_back('{id: 16'd10, addr: 40'h50_00, len: 8'd5, size: 3'd4, burst: 2'd1});
        issue(mk_pkt(1'b0, 40'h5000, 16'd10, 8'd5, 3'd4, 2'd1, 64'h0, 512'h0), lat);
        drain("long_follow_drain");
        check("long_len_error_sticky", len_error, 1);

        // Test 5: reset during the second W beat
        exp_aw.push_back('{id: 16'd12, addr: 40'h60_00, len: 8'd3, size: 3'd4, burst: 2'd1});
        for (int k = 0; k < 4; k++)
            exp_w.push_back('{data: dv[k], strb: 16'hFFFF, last: (k == 3)});
        issue(mk_pkt(1'b1, 40'h6000, 16'd12, 8'd3, 3'd4, 2'd1, {4{16'hFFFF}},
                     {dv[3], dv[2], dv[1], dv[0]}), lat);
        @(posedge clock); #1;
        check("mid_beat_is_second", {m_axi_wvalid, m_axi_wdata}, {1'b1, dv[1]});
        reset = 1'b0;
        #1;
        check("mid_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        check("mid_rst_consumed", consumed, 0);
        exp_aw.delete();
        exp_w.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("post_rst_quiet", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, consumed}, 0);
        end
        check("post_rst_len_error", len_error, 0);

        // Test 6: read with arready low for five cycles
        m_axi_arready = 1'b0;
        exp_ar.push_back('{id: 16'd21, addr: 40'h70_00, len: 8'd0, size: 3'd4, burst: 2'd1});
        issue(mk_pkt(1'b0, 40'h7000, 16'd21, 8'd0, 3'd4, 2'd1, 64'h0, 512'h0), lat);
        repeat (4) @(posedge clock);
        #1;
        m_axi_arready = 1'b1;
        drain("perf_drain");
        @(negedge clock);
`ifdef SERIALIZER_PERF_COUNTERS_EN
        check("perf_pkt_count", pkt_count, 1);
        check("perf_stall_count", stall_count, 5);
`else
        check("perf_pkt_count_off", pkt_count, 0);
        check("perf_stall_count_off", stall_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/packet_serializer.md
# packet_serializer

Output stage of the non-AXI domain. It consumes the packet chosen by the scheduler/selector pair, pulses `consumed` back to the scheduler, and replays the packet as an AXI4 master transaction toward memory. Reads issue one AR beat. Writes issue AW, then `len+1` W beats, capped at 4.

## Interface
**Parameters**
- `DATA_SIZE`, default 678: packet width, laid out as 102-bit header + 4×16 strobes + 4×128 data.
- `ID_WIDTH`, default 16: AXI ID width.
- `ADDR_WIDTH`, default 40: AXI address width.
- `HOLDOFF`, default 2: cycles after a `consumed` pulse before the next capture is allowed.

**Ports**
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `packet` in DATA_SIZE: the selector's output.
- `activate` in 1: scheduler enable; a packet is available.
- `consumed` out 1: one-cycle pulse; the packet has been captured.
- `m_axi_aw{id,addr,len,size,burst,valid}` out (ID_WIDTH, ADDR_WIDTH, 8, 3, 2, 1); `m_axi_awready` in 1.
- `m_axi_w{data,strb,last,valid}` out (128, 16, 1, 1); `m_axi_wready` in 1.
- `m_axi_ar{id,addr,len,size,burst,valid}` out (same widths as AW); `m_axi_arready` in 1.
- `len_error` out 1: sticky flag; a write packet had `len > 3`.
- `pkt_count` out 32: packets issued.
- `stall_count` out 32: cycles in which an AXI valid was held low-ready.

## Operation
- **Header layout:** [39:0] addr, [55:40] id, [63:56] len, [66:64] size, [68:67] burst, [69] is_write, [101:70] reserved (ignored). Strobe beat k is at `102+16k`; data beat k is at `166+128k`.
- **FSM:**
  - IDLE: if `activate`=1 and the holdoff counter is 0, capture `packet` into an internal register, go to ADDR.
  - ADDR: for a write, assert AW valid; on handshake go to DATA. For a read, assert AR valid; on handshake go to IDLE.
  - DATA: beat counter `beat` (2 bits) starts at 0 and increments on each W handshake. `wlast`=1 when `beat == eff_len`. The last handshake goes to IDLE.
- **Effective length:** `eff_len = min(len, 3)`.
  - `awlen` is driven with `eff_len`.
  - For a write with `len > 3`, set `len_error`. It clears only on reset.
  - Read `arlen` passes `len` through unchanged.
- **Captured register:** all AXI fields are driven from it, never from the live `packet` input.
- **`activate` outside IDLE:** ignored. A held-high `activate` never causes a double capture.
- **Holdoff counter:** loaded with `HOLDOFF` when `consumed` pulses and decrements to 0. This gives the scheduler and the registered selector time to advance.
- **Mid-operation reset:** a reset asserted mid-burst aborts immediately. All valids drop and the FSM returns to IDLE; no packet is replayed.

## Timing
- **Reset values:** every output is 0, FSM is IDLE, holdoff is 0.
- **`consumed`:** registered. It is high exactly in the first ADDR cycle, i.e. the cycle after capture.
- **Minimum latencies:**
  - Capture to AW/AR valid: 1 cycle.
  - AW handshake to first `wvalid`: 1 cycle.
  - Beats: 1 per cycle while `wready`=1.
- **Valid hold rule:** a valid, once asserted, stays high with stable payload until its ready is seen.
- **Packet spacing:**
  - Minimum read-packet spacing is 1 + 1 + `HOLDOFF` cycles.
  - A write with N beats adds N cycles.

## Configuration
- **`SERIALIZER_PERF_COUNTERS_EN`**
  - Defined: `pkt_count` increments on the AR handshake or the last W handshake. `stall_count` increments in each cycle where (`awvalid & !awready`) | (`wvalid & !wready`) | (`arvalid & !arready`). Both counters wrap at 2^32 and reset to 0.
  - Undefined: both ports are tied to 0 and no counter flops are synthesized.

## Structure
- **Shared package `memoredf_pkg`:**
  - Header field offsets and widths as localparams.
  - Typedef `packet_hdr_t` (packed struct of the header).
  - Enum `ser_state_t {IDLE, ADDR, DATA}`.
  - Beat/strobe/data widths.
- **Sub-module `beat_extractor`:** combinational mux selecting the data/strobe slice for beat index `beat`. The FSM, counters and AXI registers stay in the top level.

## Test plan
1. **Single read.** Read packet with addr=0x1000, id=3, len=0, `arready`=1 → `consumed` high at cycle 2. `arvalid` high at cycle 2 with `araddr`=0x1000, `arid`=3. No AW/W activity.
2. **Four-beat write with back-pressure.** Write packet, len=3, strobes all 0xFFFF, data beats D0..D3; `wready` toggles 1,0,1,0 → exactly 4 W handshakes in order D0..D3, `wlast` only on D3, and `wdata` stable during stalls.
3. **Held `activate`.** `activate` held high across two packets → exactly two `consumed` pulses, separated by at least 2+`HOLDOFF` cycles. No duplicate AR.
4. **Overlong write.** Write with len=7 → `awlen`=3, 4 beats issued, `len_error`=1 after capture and still 1 after the next packet.
5. **Reset mid-burst.** `reset` asserted low during the second W beat → all valids are 0 in the same cycle. After release, the FSM is IDLE and `consumed` is 0.
6. **Perf counters.** With `SERIALIZER_PERF_COUNTERS_EN` defined, one read with `arready` low for 5 cycles → `pkt_count`=1, `stall_count`=5. With the macro undefined, both ports read 0.
